div: RTL and testbench

- Multi-cycle iterative divider beside the execute stage of the 5-stage pipeline.
- The ex stage launches DIV/DIVU operands; the divider returns the 64-bit {remainder, quotient} for the HI/LO write path.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Pipeline stall control uses ready_o as the stall-release signal.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/div.sv | 172 +++++++++++++++++
 tb/tb_div.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   RegBusW           : architectural register width
//   div_state_e       : divider FSM states (encodings fixed for the HI/LO path)
//   DivResultReady/NotReady : ready_o levels
package div_pkg;

  localparam int unsigned RegBusW = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
//   i_rem      : partial remainder before the step
//   i_dividend : dividend shift register (quotient bits fill in from the LSB)
//   i_divisor  : unsigned divisor magnitude
//   o_rem      : partial remainder after the step
//   o_dividend : shifted dividend with the new quotient bit in bit 0
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_dividend
);

  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  // Compare on DATA_W+1 bits; after a subtract the result is below the divisor,
  // so only the low DATA_W bits of the difference are ever kept.
  assign w_shift    = {i_rem, i_dividend[DATA_W-1]};
  assign w_ge       = (w_shift >= {1'b0, i_divisor});
  assign w_diff     = w_shift[DATA_W-1:0] - i_divisor;
  assign o_rem      = w_ge ? w_diff : w_shift[DATA_W-1:0];
  assign o_dividend = {i_dividend[DATA_W-2:0], w_ge};

endmodule

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU beside the execute stage.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = signed DIV, 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held until ready_o is seen
//   annul_i      : cancel, has priority over start_i
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
// Optional: define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  div_state_e          r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_dividend, w_dividend_nxt;
  logic [DATA_W-1:0]   r_divisor, w_divisor_nxt;
  logic [DATA_W-1:0]   r_rem, w_rem_nxt;
  logic                r_neg_quot, w_neg_quot_nxt;
  logic                r_neg_rem, w_neg_rem_nxt;
  logic [2*DATA_W-1:0] r_result, w_result_nxt;
  logic                r_ready, w_ready_nxt;

  logic [DATA_W-1:0]   w_op1_abs, w_op2_abs;
  logic [DATA_W-1:0]   w_step_rem, w_step_dividend;
  logic [DATA_W-1:0]   w_quot_fin, w_rem_fin;
  logic                w_early;

  assign w_op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_op1_abs < w_op2_abs);
`else
  assign w_early = 1'b0;
`endif

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .i_rem      (r_rem),
    .i_dividend (r_dividend),
    .i_divisor  (r_divisor),
    .o_rem      (w_step_rem),
    .o_dividend (w_step_dividend)
  );

  // Sign correction on the final step: quotient negative when signs differ,
  // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  assign w_quot_fin = r_neg_quot ? ('0 - w_step_dividend) : w_step_dividend;
  assign w_rem_fin  = r_neg_rem  ? ('0 - w_step_rem)      : w_step_rem;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_rem_nxt      = r_rem;
    w_neg_quot_nxt = r_neg_quot;
    w_neg_rem_nxt  = r_neg_rem;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;

    case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DivByZero;
          end else if (w_early) begin
            w_state_nxt  = DivEnd;
            w_result_nxt = {opdata1_i, {DATA_W{1'b0}}};
            w_ready_nxt  = DivResultReady;
          end else begin
            w_state_nxt    = DivOn;
            w_cnt_nxt      = '0;
            w_dividend_nxt = w_op1_abs;
            w_divisor_nxt  = w_op2_abs;
            w_rem_nxt      = '0;
            w_neg_quot_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            w_neg_rem_nxt  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end

      DivOn: begin
        if (annul_i) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = '0;
        end else begin
          w_rem_nxt      = w_step_rem;
          w_dividend_nxt = w_step_dividend;
          w_cnt_nxt      = r_cnt + CntW'(1);
          if (r_cnt == CntW'(DATA_W - 1)) begin
            w_state_nxt  = DivEnd;
            w_result_nxt = {w_rem_fin, w_quot_fin};
            w_ready_nxt  = DivResultReady;
          end
        end
      end

      // Zero divisor reaches DivEnd with ready low; DivEnd raises it one edge later.
      DivByZero: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
        w_state_nxt  = annul_i ? DivFree : DivEnd;
      end

      DivEnd: begin
        if (annul_i || !start_i) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = '0;
        end else begin
          w_ready_nxt = DivResultReady;
        end
      end

      default: begin
        w_state_nxt  = DivFree;
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_rem      <= w_rem_nxt;
      r_neg_quot <= w_neg_quot_nxt;
      r_neg_rem  <= w_neg_rem_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: a driver issues directed operations and queues the
// expected {remainder, quotient} and latency; a monitor checks each ready_o rise.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          e0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SmallLat = 0;
`else
  localparam int SmallLat = 32;
`endif

  div #(
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: every rising ready_o must match the oldest queued expectation.
  initial begin
    logic prev_ready;
    exp_t it;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o && !prev_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: ready_o rose with result %h, none expected", result_o);
        end else begin
          it = sb.pop_front();
          total++;
          if (result_o !== it.res) begin
            bad++;
            $display("FAIL %s result: got %h want %h", it.name, result_o, it.res);
          end
          total++;
          if (cyc - it.e0 != it.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", it.name, cyc - it.e0, it.lat);
          end
        end
      end
      prev_ready = ready_o;
    end
  end

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after start has been dropped.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int lat, input string name);
    bit got;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb.push_back('{res: exp_res, lat: lat, e0: cyc + 1, name: name});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: ready_o low after 40 cycles, want high", name);
    end else begin
      @(negedge clk);
      check({name, " held"}, {ready_o, result_o}, {1'b1, exp_res});
    end
    start_i = 1'b0;
    @(negedge clk);
    check({name, " drop"}, {ready_o, result_o}, {1'b0, 64'h0});
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {ready_o, result_o}, {1'b0, 64'h0});
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},                32, "u100_7");
    run_op(1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  32, "s-7_2");
    run_op(1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD},  32, "s7_-2");
    run_op(1'b0, 32'h1234,      32'd0,          64'h0,                          2, "divzero");
    run_op(1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h0, 32'h80000000},         32, "s_ovf");
    run_op(1'b0, 32'hFFFFFFFF,  32'h10,         {32'hF, 32'h0FFFFFFF},         32, "u_max_16");
    run_op(1'b0, 32'd5,         32'd9,          {32'd5, 32'd0},          SmallLat, "u5_9");
    run_op(1'b1, 32'hFFFFFFFB,  32'd9,          {32'hFFFFFFFB, 32'd0},   SmallLat, "s-5_9");

    // Annul mid-division: no result, then a fresh start is accepted.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("annul_idle", {ready_o, result_o}, {1'b0, 64'h0});
    annul_i = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, "after_annul");

    // Reset mid-division: same recovery.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (11) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("rst_idle", {ready_o, result_o}, {1'b0, 64'h0});
    rst = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, "after_rst");

    repeat (5) @(negedge clk);
    check("sb_empty", 65'(sb.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule
